lap_stopwatch_core: RTL and testbench
=====================================

Name: lap_stopwatch_core

Overview:
Parametrised stopwatch/timer core. It merges the tick divider, BCD time counter, lap store, display select and blink generator into one block.
- Supports count-up and count-down (preset) modes, with a 32-bit BCD time word (HH:MM:SS.CC).
- Holds an internal lap register file of configurable depth.
- Sits between the debounced button pulses and the seven-segment controller, replacing the separate divider/counter/memory/mux path.

Parameters:
TICK_DIV, 1000000, clk cycles per 10 ms tick (min 2)
LAP_DEPTH, 16, number of lap slots (power of two, 2..64)
ADDR_W, 4, lap address width, = log2(LAP_DEPTH)
BLINK_TICKS, 50, ticks per blink half-period

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start_stop  in  1  one-cycle pulse: start/pause/resume
lap  in  1  one-cycle pulse: store current time
clear  in  1  one-cycle pulse: return to IDLE
mode  in  1  0 = count up, 1 = count down; sampled in IDLE only
preset_we  in  1  load preset_in; accepted in IDLE only
preset_in  in  32  BCD preset {HH,MM,SS,CC}
view  in  1  0 = live time, 1 = lap readback
rd_addr  in  ADDR_W  lap slot to read
disp_data  out  32  registered BCD word for the display
running  out  1  high in RUN
done  out  1  high in DONE
lap_count  out  ADDR_W+1  number of stored laps
lap_full  out  1  lap_count == LAP_DEPTH
preset_err  out  1  one-cycle pulse on a rejected preset
blink  out  1  half-period square wave in RUN, 0 otherwise

Behaviour:
Reset (reset = 0, asynchronous):
- State IDLE; time, preset, lap_count, divider and blink counters = 0.
- All outputs 0; lap contents are don't-care.

State machine: IDLE, RUN, PAUSE, DONE.
- IDLE --start_stop--> RUN.
- RUN --start_stop--> PAUSE; PAUSE --start_stop--> RUN.
- RUN --terminal count--> DONE; start_stop is ignored in DONE.
- clear from any state --> IDLE. Time reloads to 0 (mode 0) or to the preset (mode 1); lap_count = 0; divider = 0.
- clear and start_stop in the same cycle: clear wins.
- The mode register is latched while in IDLE only.

Divider:
- Counts 0..TICK_DIV-1 in RUN only; holds in PAUSE.
- tick = 1 for one cycle at TICK_DIV-1, then the divider wraps to 0.

Time counter (BCD), updated on tick:
- Digit ranges: CC 00-99, SS 00-59, MM 00-59, HH 00-99; carry/borrow ripples through them.
- Up mode: 99:59:59.99 is terminal. The value holds and the state goes to DONE on that tick.
- Down mode: on the tick that reaches 00:00:00.00, the state goes to DONE.
- Down mode with preset 0 on start: the state goes to DONE on the first tick, and the time stays 0.

Preset:
- preset_we in IDLE checks every digit is <= 9 and that the SS/MM tens digits are <= 5.
- Valid preset: the preset register loads; if mode = 1, the time also loads on the next cycle.
- Invalid preset: the load is ignored and preset_err pulses.
- preset_we outside IDLE: ignored, no preset_err.

Lap store:
- lap in RUN, PAUSE or DONE with !lap_full: the current time register value (pre-tick value if tick is in the same cycle) is written to slot lap_count, and lap_count increments.
- lap in IDLE or with lap_full: ignored.
- Readback is a registered read, 1-cycle latency. If rd_addr >= lap_count, the read data is 0.

Display:
- disp_data is registered.
- view = 0: the time register, 1 cycle behind.
- view = 1: the lap read data, 2 cycles after rd_addr.

Blink:
- In RUN, blink toggles every BLINK_TICKS ticks.
- On leaving RUN, the blink counter clears and blink = 0.

Test Plan:
1. TICK_DIV = 2, mode 0, start_stop, run 300 cycles (150 ticks) -> time 00:00:01.50, running = 1; start_stop -> PAUSE, value frozen for 100 cycles.
2. Preset 00:00:00.03, mode 1, start -> 00:00:00.02, .01, .00 on successive ticks; done = 1 on the .00 tick; running = 0; further start_stop ignored; clear -> time = preset, IDLE.
3. Preset_in 00:00:75:00 (SS tens = 7) -> preset_err pulse, preset unchanged; preset_we in RUN -> no effect, no error.
4. LAP_DEPTH = 4: five lap pulses at distinct times -> lap_count = 4, lap_full = 1, 5th ignored. view = 1, rd_addr = 0..3 -> stored values after 2 cycles; rd_addr beyond lap_count after clear -> 0.
5. lap coincident with tick carrying 00:00:00.99 -> 00:00:01.00 -> stored lap = 00:00:00.99. clear + start_stop same cycle -> IDLE.
6. Up mode from preset-forced 99:59:59.98 -> DONE at 99:59:59.99, value holds. Async reset asserted mid-RUN -> all outputs 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/lap_stopwatch_core.sv
// Stopwatch/timer core: tick divider, BCD HH:MM:SS.CC counter, lap register file,
// display select and blink generator, driven by single-cycle button pulses.
module lap_stopwatch_core #(
    parameter int TICK_DIV    = 1000000,
    parameter int LAP_DEPTH   = 16,
    parameter int ADDR_W      = 4,
    parameter int BLINK_TICKS = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_stop,
    input  logic              lap,
    input  logic              clear,
    input  logic              mode,
    input  logic              preset_we,
    input  logic [31:0]       preset_in,
    input  logic              view,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       disp_data,
    output logic              running,
    output logic              done,
    output logic [ADDR_W:0]   lap_count,
    output logic              lap_full,
    output logic              preset_err,
    output logic              blink
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int BL_W  = $clog2(BLINK_TICKS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [31:0]      TERM_UP  = 32'h9959_5999;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BL_W-1:0]  BL_MAX   = BL_W'(BLINK_TICKS - 1);
    localparam logic [BL_W-1:0]  BL_ONE   = BL_W'(1);
    localparam logic [ADDR_W:0]  LAP_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]  LAP_MAX  = (ADDR_W + 1)'(LAP_DEPTH);

    // One BCD step up or down; digits 3 and 5 (SS/MM tens) roll at 5, all others at 9.
    function automatic logic [31:0] bcd_step(input logic [31:0] t, input logic down);
        logic [31:0] r;
        logic        c;
        logic [3:0]  d;
        logic [3:0]  lim;
        r = t;
        c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d   = t[4*i +: 4];
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (c) begin
                if (down) begin
                    if (d == 4'd0) begin
                        r[4*i +: 4] = lim;
                    end else begin
                        r[4*i +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == lim) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [31:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (t[4*i +: 4] > ((i == 3 || i == 5) ? 4'd5 : 4'd9)) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    logic [1:0]        state_r, state_nxt_s;
    logic              mode_r, pending_r;
    logic [31:0]       time_r, time_nxt_s, preset_r, step_s, term_s;
    logic [DIV_W-1:0]  div_r, div_nxt_s;
    logic [BL_W-1:0]   blink_cnt_r, blink_cnt_nxt_s;
    logic              blink_r, blink_nxt_s;
    logic [ADDR_W:0]   lap_count_r, lap_count_nxt_s;
    logic              lap_full_r, preset_err_r, running_r, done_r;
    logic [31:0]       rd_data_r, disp_r;
    logic [31:0]       lap_mem_r [LAP_DEPTH];
    logic              tick_s, at_term_s, lap_wr_s, preset_ok_s, preset_bad_s;

    assign tick_s       = (state_r == ST_RUN) && (div_r == DIV_MAX);
    assign step_s       = bcd_step(time_r, mode_r);
    assign term_s       = mode_r ? 32'd0 : TERM_UP;
    assign at_term_s    = (time_r == term_s);
    assign lap_wr_s     = lap && (state_r != ST_IDLE) && !lap_full_r && !clear;
    assign preset_ok_s  = preset_we && (state_r == ST_IDLE) && bcd_valid(preset_in);
    assign preset_bad_s = preset_we && (state_r == ST_IDLE) && !bcd_valid(preset_in);

    // Next-state, time, divider, lap count and blink computation.
    always_comb begin
        state_nxt_s     = state_r;
        time_nxt_s      = time_r;
        div_nxt_s       = div_r;
        lap_count_nxt_s = lap_count_r;
        blink_cnt_nxt_s = blink_cnt_r;
        blink_nxt_s     = blink_r;
        if (clear) begin
            state_nxt_s     = ST_IDLE;
            time_nxt_s      = mode_r ? preset_r : 32'd0;
            div_nxt_s       = '0;
            lap_count_nxt_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pending_r && mode_r) begin
                        time_nxt_s = preset_r;
                    end else begin
                        time_nxt_s = time_r;
                    end
                    state_nxt_s = start_stop ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (tick_s) begin
                        div_nxt_s = '0;
                        // A terminal value already held (e.g. down from preset 0) ends without stepping.
                        if (at_term_s) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            time_nxt_s = step_s;
                            if (step_s == term_s) begin
                                state_nxt_s = ST_DONE;
                            end else begin
                                state_nxt_s = start_stop ? ST_PAUSE : ST_RUN;
                            end
                        end
                    end else begin
                        div_nxt_s   = div_r + DIV_ONE;
                        state_nxt_s = start_stop ? ST_PAUSE : ST_RUN;
                    end
                end
                ST_PAUSE: state_nxt_s = start_stop ? ST_RUN : ST_PAUSE;
                ST_DONE:  state_nxt_s = ST_DONE;
                default:  state_nxt_s = ST_IDLE;
            endcase
            if (lap_wr_s) begin
                lap_count_nxt_s = lap_count_r + LAP_ONE;
            end else begin
                lap_count_nxt_s = lap_count_r;
            end
        end
        if (state_nxt_s != ST_RUN) begin
            blink_cnt_nxt_s = '0;
            blink_nxt_s     = 1'b0;
        end else if (tick_s) begin
            if (blink_cnt_r == BL_MAX) begin
                blink_cnt_nxt_s = '0;
                blink_nxt_s     = ~blink_r;
            end else begin
                blink_cnt_nxt_s = blink_cnt_r + BL_ONE;
                blink_nxt_s     = blink_r;
            end
        end else begin
            blink_cnt_nxt_s = blink_cnt_r;
            blink_nxt_s     = blink_r;
        end
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            mode_r       <= 1'b0;
            pending_r    <= 1'b0;
            time_r       <= 32'd0;
            preset_r     <= 32'd0;
            div_r        <= '0;
            blink_cnt_r  <= '0;
            blink_r      <= 1'b0;
            lap_count_r  <= '0;
            lap_full_r   <= 1'b0;
            preset_err_r <= 1'b0;
            running_r    <= 1'b0;
            done_r       <= 1'b0;
            rd_data_r    <= 32'd0;
            disp_r       <= 32'd0;
        end else begin
            state_r      <= state_nxt_s;
            mode_r       <= (state_r == ST_IDLE) ? mode : mode_r;
            pending_r    <= preset_ok_s;
            time_r       <= time_nxt_s;
            preset_r     <= preset_ok_s ? preset_in : preset_r;
            div_r        <= div_nxt_s;
            blink_cnt_r  <= blink_cnt_nxt_s;
            blink_r      <= blink_nxt_s;
            lap_count_r  <= lap_count_nxt_s;
            lap_full_r   <= (lap_count_nxt_s == LAP_MAX);
            preset_err_r <= preset_bad_s;
            running_r    <= (state_nxt_s == ST_RUN);
            done_r       <= (state_nxt_s == ST_DONE);
            rd_data_r    <= ({1'b0, rd_addr} < lap_count_r) ? lap_mem_r[rd_addr] : 32'd0;
            disp_r       <= view ? rd_data_r : time_r;
        end
    end

    // Lap storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (lap_wr_s) begin
            lap_mem_r[lap_count_r[ADDR_W-1:0]] <= time_r;
        end
    end

    assign disp_data  = disp_r;
    assign running    = running_r;
    assign done       = done_r;
    assign lap_count  = lap_count_r;
    assign lap_full   = lap_full_r;
    assign preset_err = preset_err_r;
    assign blink      = blink_r;

endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Directed bench for lap_stopwatch_core: preset validation table plus hand-timed
// sequences for counting, pause, down-count terminal, laps, readback and reset.
module tb_lap_stopwatch_core;

    localparam int TICK_DIV    = 2;
    localparam int LAP_DEPTH   = 4;
    localparam int ADDR_W      = 2;
    localparam int BLINK_TICKS = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start_stop = 1'b0;
    logic              lap = 1'b0;
    logic              clear = 1'b0;
    logic              mode = 1'b0;
    logic              preset_we = 1'b0;
    logic [31:0]       preset_in = 32'd0;
    logic              view = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [31:0]       disp_data;
    logic              running, done, lap_full, preset_err, blink;
    logic [ADDR_W:0]   lap_count;

    int checks = 0;
    int errors = 0;

    lap_stopwatch_core #(
        .TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH), .ADDR_W(ADDR_W), .BLINK_TICKS(BLINK_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
        .mode(mode), .preset_we(preset_we), .preset_in(preset_in), .view(view),
        .rd_addr(rd_addr), .disp_data(disp_data), .running(running), .done(done),
        .lap_count(lap_count), .lap_full(lap_full), .preset_err(preset_err), .blink(blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] preset;
        logic        exp_err;
        logic [31:0] exp_disp;
    } pvec_t;

    pvec_t       pv [7];
    logic [31:0] exp_lap [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pv[0] = '{32'h0000_7500, 1'b1, 32'h0000_0000};
        pv[1] = '{32'h9959_5999, 1'b0, 32'h0000_0000};
        pv[2] = '{32'h0000_000A, 1'b1, 32'h9959_5999};
        pv[3] = '{32'h0060_0000, 1'b1, 32'h9959_5999};
        pv[4] = '{32'hA000_0000, 1'b1, 32'h9959_5999};
        pv[5] = '{32'h0000_0A00, 1'b1, 32'h9959_5999};
        pv[6] = '{32'h0000_0003, 1'b0, 32'h9959_5999};
        for (int i = 0; i < 4; i++) exp_lap[i] = 32'(2 * i + 1);

        // Reset state
        cyc(2);
        check("rst_disp", disp_data, 32'd0);
        check("rst_flags", {26'd0, running, done, lap_full, preset_err, blink, 1'b0}, 32'd0);
        check("rst_lap_count", {29'd0, lap_count}, 32'd0);
        reset = 1'b1;
        cyc(1);

        // Count up, blink, pause
        start_stop = 1'b1; cyc(1); start_stop = 1'b0;
        check("run_running", {31'd0, running}, 32'd1);
        cyc(5);
        check("blink_before", {31'd0, blink}, 32'd0);
        cyc(1);
        check("blink_toggle", {31'd0, blink}, 32'd1);
        cyc(294);
        check("up_1_49", disp_data, 32'h0000_0149);
        start_stop = 1'b1; cyc(1); start_stop = 1'b0;
        check("pause_running", {31'd0, running}, 32'd0);
        check("pause_blink", {31'd0, blink}, 32'd0);
        check("up_1_50", disp_data, 32'h0000_0150);
        cyc(100);
        check("pause_hold", disp_data, 32'h0000_0150);

        // Preset validation table in IDLE, mode 1
        clear = 1'b1; mode = 1'b1; cyc(1); clear = 1'b0;
        for (int i = 0; i < 7; i++) begin
            preset_in = pv[i].preset; preset_we = 1'b1; cyc(1); preset_we = 1'b0;
            check($sformatf("preset_err_%0d", i), {31'd0, preset_err}, {31'd0, pv[i].exp_err});
            cyc(1);
            check($sformatf("preset_pulse_%0d", i), {31'd0, preset_err}, 32'd0);
            check($sformatf("preset_time_%0d", i), disp_data, pv[i].exp_disp);
        end
        cyc(1);
        check("preset_loaded", disp_data, 32'h0000_0003);

        // Down count to terminal
        start_stop = 1'b1; cyc(1); start_stop = 1'b0;
        cyc(3);
        check("down_02", disp_data, 32'h0000_0002);
        cyc(2);
        check("down_01", disp_data, 32'h0000_0001);
        check("down_not_done", {31'd0, done}, 32'd0);
        cyc(1);
        check("down_done", {30'd0, done, running}, 32'd2);
        cyc(1);
        check("down_00", disp_data, 32'h0000_0000);
        start_stop = 1'b1; cyc(1); start_stop = 1'b0;
        check("done_ignores_ss", {30'd0, done, running}, 32'd2);
        cyc(4);
        check("done_hold", disp_data, 32'h0000_0000);
        clear = 1'b1; cyc(1); clear = 1'b0;
        check("clear_done", {30'd0, done, running}, 32'd0);
        cyc(1);
        check("clear_reload", disp_data, 32'h0000_0003);

        // preset_we outside IDLE
        start_stop = 1'b1; cyc(1); start_stop = 1'b0;
        preset_in = 32'h0000_1234; preset_we = 1'b1; cyc(1); preset_we = 1'b0;
        check("run_preset_noerr", {31'd0, preset_err}, 32'd0);
        clear = 1'b1; cyc(1); clear = 1'b0;
        cyc(1);
        check("run_preset_ignored", disp_data, 32'h0000_0003);

        // Laps, full store, readback
        mode = 1'b0; cyc(1);
        clear = 1'b1; cyc(1); clear = 1'b0;
        start_stop = 1'b1; cyc(1); start_stop = 1'b0;
        cyc(2);
        for (int k = 0; k < 5; k++) begin
            lap = 1'b1; cyc(1); lap = 1'b0;
            check($sformatf("lap_count_%0d", k), {29'd0, lap_count}, (k < 4) ? 32'(k + 1) : 32'd4);
            cyc(3);
        end
        check("lap_full", {31'd0, lap_full}, 32'd1);
        view = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = ADDR_W'(i); cyc(2);
            check($sformatf("lap_read_%0d", i), disp_data, exp_lap[i]);
        end
        clear = 1'b1; cyc(1); clear = 1'b0;
        check("clear_laps", {29'd0, lap_count}, 32'd0);
        check("clear_full", {31'd0, lap_full}, 32'd0);
        rd_addr = 2'd0; cyc(2);
        check("read_empty_0", disp_data, 32'd0);
        rd_addr = 2'd3; cyc(2);
        check("read_empty_3", disp_data, 32'd0);

        // Lap coincident with the .99 -> 1.00 tick
        view = 1'b0;
        start_stop = 1'b1; cyc(1); start_stop = 1'b0;
        cyc(199);
        lap = 1'b1; cyc(1); lap = 1'b0;
        check("lap_tick_count", {29'd0, lap_count}, 32'd1);
        cyc(1);
        check("live_1_00", disp_data, 32'h0000_0100);
        view = 1'b1; rd_addr = 2'd0; cyc(2);
        check("lap_pre_tick", disp_data, 32'h0000_0099);
        view = 1'b0;
        clear = 1'b1; start_stop = 1'b1; cyc(1); clear = 1'b0; start_stop = 1'b0;
        check("clear_wins", {30'd0, done, running}, 32'd0);
        cyc(3);
        check("clear_wins_idle", {30'd0, done, running}, 32'd0);
        check("clear_wins_time", disp_data, 32'd0);

        // Up-count terminal from a forced 99:59:59.98
        mode = 1'b1; preset_in = 32'h9959_5998; preset_we = 1'b1; cyc(1); preset_we = 1'b0;
        check("term_preset_ok", {31'd0, preset_err}, 32'd0);
        cyc(1);
        mode = 1'b0; cyc(1);
        start_stop = 1'b1; cyc(1); start_stop = 1'b0;
        check("term_running", {31'd0, running}, 32'd1);
        cyc(2);
        check("term_done", {30'd0, done, running}, 32'd2);
        cyc(1);
        check("term_value", disp_data, 32'h9959_5999);
        cyc(5);
        check("term_hold", disp_data, 32'h9959_5999);

        // Async reset mid-RUN
        clear = 1'b1; cyc(1); clear = 1'b0;
        start_stop = 1'b1; cyc(1); start_stop = 1'b0;
        cyc(7);
        check("pre_reset_blink", {30'd0, running, blink}, 32'd3);
        #2 reset = 1'b0;
        #1;
        check("async_disp", disp_data, 32'd0);
        check("async_flags", {27'd0, running, done, lap_full, preset_err, blink}, 32'd0);
        cyc(2);
        reset = 1'b1;
        cyc(3);
        check("post_reset_idle", {30'd0, running, done}, 32'd0);
        check("post_reset_time", disp_data, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
